// File: rtl/dma_burst_engine.sv
// dma_burst_engine: single-channel AXI4 memory-to-memory DMA master.
// Moves data as read-burst / write-burst pairs through a MAX_BURST-word buffer.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

module dma_burst_engine #(
    parameter int MAX_BURST = 16,
    parameter int DMA_ID    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       DMAEN,
    input  logic [31:0]                DMASRC,
    input  logic [31:0]                DMADST,
    input  logic [31:0]                DMALEN,
    input  logic                       DMA_clr,
    output logic                       DMA_interrupt,
    output logic                       DMA_error,
    output logic                       DMA_busy,
    output logic [`AXI_ID_BITS-1:0]    M_AWID,
    output logic [`AXI_ADDR_BITS-1:0]  M_AWAddr,
    output logic [`AXI_LEN_BITS-1:0]   M_AWLen,
    output logic [`AXI_SIZE_BITS-1:0]  M_AWSize,
    output logic [`AXI_BURST_BITS-1:0] M_AWBurst,
    output logic                       M_AWValid,
    input  logic                       M_AWReady,
    output logic [`AXI_DATA_BITS-1:0]  M_WData,
    output logic [`AXI_STRB_BITS-1:0]  M_WStrb,
    output logic                       M_WLast,
    output logic                       M_WValid,
    input  logic                       M_WReady,
    input  logic [`AXI_ID_BITS-1:0]    M_BID,
    input  logic [`AXI_RESP_BITS-1:0]  M_BResp,
    input  logic                       M_BValid,
    output logic                       M_BReady,
    output logic [`AXI_ID_BITS-1:0]    M_ARID,
    output logic [`AXI_ADDR_BITS-1:0]  M_ARAddr,
    output logic [`AXI_LEN_BITS-1:0]   M_ARLen,
    output logic [`AXI_SIZE_BITS-1:0]  M_ARSize,
    output logic [`AXI_BURST_BITS-1:0] M_ARBurst,
    output logic                       M_ARValid,
    input  logic                       M_ARReady,
    input  logic [`AXI_ID_BITS-1:0]    M_RID,
    input  logic [`AXI_DATA_BITS-1:0]  M_RData,
    input  logic [`AXI_RESP_BITS-1:0]  M_RResp,
    input  logic                       M_RLast,
    input  logic                       M_RValid,
    output logic                       M_RReady
);

    localparam int IW = $clog2(MAX_BURST);
    localparam int BW = IW + 1;

    typedef enum logic [2:0] {
        IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   src_q, src_d, dst_q, dst_d, rem_q, rem_d;
    logic [BW-1:0] blen_q, blen_d;
    logic [IW-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic          err_q, err_d, intr_q, intr_d, derr_q, derr_d;
    logic          arv_q, arv_d, rrdy_q, rrdy_d, awv_q, awv_d;
    logic          wv_q, wv_d, brdy_q, brdy_d, busy_q, busy_d;
    logic [31:0]   mem_q [MAX_BURST];
    logic          mem_we;
    logic          wlast;
    logic          unused_bits;

    // Largest burst that fits the remaining count, the buffer and both 4 KB pages
    function automatic logic [BW-1:0] burst_len(input logic [31:0] s,
                                                 input logic [31:0] d,
                                                 input logic [31:0] r);
        logic [31:0] m, bs, bd;
        m  = (r > 32'(MAX_BURST)) ? 32'(MAX_BURST) : r;
        bs = 32'd1024 - {22'd0, s[11:2]};
        bd = 32'd1024 - {22'd0, d[11:2]};
        if (bs < m) m = bs;
        if (bd < m) m = bd;
        return BW'(m);
    endfunction

    assign wlast = (wcnt_q == IW'(blen_q - BW'(1)));

    // Next-state, pointer, counter and sticky-flag computation
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        blen_d  = blen_q;
        rcnt_d  = rcnt_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        intr_d  = DMA_clr ? 1'b0 : intr_q;
        derr_d  = DMA_clr ? 1'b0 : derr_q;
        unique case (state_q)
            IDLE: begin
                if (DMAEN && !intr_q) begin
                    src_d = {DMASRC[31:2], 2'b00};
                    dst_d = {DMADST[31:2], 2'b00};
                    rem_d = DMALEN;
                    if (DMALEN == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RADDR;
                        blen_d  = burst_len(src_d, dst_d, rem_d);
                    end
                end
            end
            RADDR: if (arv_q && M_ARReady) state_d = RDATA;
            RDATA: begin
                if (rrdy_q && M_RValid) begin
                    mem_we = 1'b1;
                    rcnt_d = rcnt_q + IW'(1);
                    if (M_RResp != '0) err_d = 1'b1;
                    if (M_RLast) begin
                        rcnt_d  = '0;
                        state_d = WADDR;
                    end
                end
            end
            WADDR: if (awv_q && M_AWReady) state_d = WDATA;
            WDATA: begin
                if (wv_q && M_WReady) begin
                    wcnt_d = wcnt_q + IW'(1);
                    if (wlast) begin
                        wcnt_d  = '0;
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                if (brdy_q && M_BValid) begin
                    src_d = src_q + 32'({blen_q, 2'b00});
                    dst_d = dst_q + 32'({blen_q, 2'b00});
                    rem_d = rem_q - 32'(blen_q);
                    if (M_BResp != '0) err_d = 1'b1;
                    if (err_q || M_BResp != '0 || rem_d == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RADDR;
                        blen_d  = burst_len(src_d, dst_d, rem_d);
                    end
                end
            end
            DONE: begin
                intr_d  = 1'b1;
                derr_d  = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        arv_d  = (state_d == RADDR);
        rrdy_d = (state_d == RDATA);
        awv_d  = (state_d == WADDR);
        wv_d   = (state_d == WDATA);
        brdy_d = (state_d == WRESP);
        busy_d = !(state_d == IDLE || state_d == DONE);
    end

    // FSM state, datapath registers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            intr_q  <= 1'b0;
            derr_q  <= 1'b0;
            arv_q   <= 1'b0;
            rrdy_q  <= 1'b0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            brdy_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            intr_q  <= intr_d;
            derr_q  <= derr_d;
            arv_q   <= arv_d;
            rrdy_q  <= rrdy_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
            brdy_q  <= brdy_d;
            busy_q  <= busy_d;
        end
    end

    // Burst buffer: read beats land here, write beats drain from here
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[rcnt_q] <= M_RData;
    end

    assign DMA_interrupt = intr_q;
    assign DMA_error     = derr_q;
    assign DMA_busy      = busy_q;

    assign M_ARID    = `AXI_ID_BITS'(DMA_ID);
    assign M_ARAddr  = src_q;
    assign M_ARLen   = `AXI_LEN_BITS'(blen_q - BW'(1));
    assign M_ARSize  = `AXI_SIZE_BITS'd2;
    assign M_ARBurst = `AXI_BURST_BITS'd1;
    assign M_ARValid = arv_q;
    assign M_RReady  = rrdy_q;

    assign M_AWID    = `AXI_ID_BITS'(DMA_ID);
    assign M_AWAddr  = dst_q;
    assign M_AWLen   = `AXI_LEN_BITS'(blen_q - BW'(1));
    assign M_AWSize  = `AXI_SIZE_BITS'd2;
    assign M_AWBurst = `AXI_BURST_BITS'd1;
    assign M_AWValid = awv_q;
    assign M_WData   = mem_q[wcnt_q];
    assign M_WStrb   = `AXI_STRB_BITS'hF;
    assign M_WLast   = wlast;
    assign M_WValid  = wv_q;
    assign M_BReady  = brdy_q;

    assign unused_bits = ^{DMASRC[1:0], DMADST[1:0], M_BID, M_RID};

endmodule

// File: tb/tb_dma_burst_engine.sv
// tb_dma_burst_engine: directed tests for dma_burst_engine against a
// behavioural AXI slave with optional random stalls and B-response errors.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

module tb_dma_burst_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        DMAEN, DMA_clr;
    logic [31:0] DMASRC, DMADST, DMALEN;
    logic        DMA_interrupt, DMA_error, DMA_busy;

    logic [`AXI_ID_BITS-1:0]    M_AWID, M_ARID;
    logic [`AXI_ADDR_BITS-1:0]  M_AWAddr, M_ARAddr;
    logic [`AXI_LEN_BITS-1:0]   M_AWLen, M_ARLen;
    logic [`AXI_SIZE_BITS-1:0]  M_AWSize, M_ARSize;
    logic [`AXI_BURST_BITS-1:0] M_AWBurst, M_ARBurst;
    logic                       M_AWValid, M_ARValid;
    logic [`AXI_DATA_BITS-1:0]  M_WData;
    logic [`AXI_STRB_BITS-1:0]  M_WStrb;
    logic                       M_WLast, M_WValid, M_BReady, M_RReady;

    logic                       ar_ready, aw_ready, w_ready;
    logic                       r_valid, r_last, b_valid;
    logic [31:0]                r_data;
    logic [`AXI_RESP_BITS-1:0]  r_resp, b_resp;
    logic [`AXI_ID_BITS-1:0]    s_id;

    dma_burst_engine #(.MAX_BURST(16), .DMA_ID(0)) dut (
        .clk(clk), .rst(rst),
        .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
        .DMA_clr(DMA_clr), .DMA_interrupt(DMA_interrupt),
        .DMA_error(DMA_error), .DMA_busy(DMA_busy),
        .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen),
        .M_AWSize(M_AWSize), .M_AWBurst(M_AWBurst),
        .M_AWValid(M_AWValid), .M_AWReady(aw_ready),
        .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast),
        .M_WValid(M_WValid), .M_WReady(w_ready),
        .M_BID(s_id), .M_BResp(b_resp), .M_BValid(b_valid), .M_BReady(M_BReady),
        .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen),
        .M_ARSize(M_ARSize), .M_ARBurst(M_ARBurst),
        .M_ARValid(M_ARValid), .M_ARReady(ar_ready),
        .M_RID(s_id), .M_RData(r_data), .M_RResp(r_resp), .M_RLast(r_last),
        .M_RValid(r_valid), .M_RReady(M_RReady)
    );

    int checks = 0;
    int errors = 0;

    bit stall = 1'b0;
    int berr_idx = -1;
    int b_cnt = 0;
    int r_beats = 0;

    logic [31:0] mem [0:16383];
    logic [31:0] ar_addrs[$], aw_addrs[$];
    logic [7:0]  ar_lens[$], aw_lens[$];

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0001_0003) ^ 32'hA5C3_0000;
    endfunction

    // Behavioural AXI slave, evaluated once per falling edge
    bit          hs_ar, hs_r, hs_aw, hs_w, hs_b;
    bit          p_arv, p_awv, p_wv;
    logic [31:0] s_araddr, s_awaddr, s_wdata, p_wdata;
    logic [7:0]  s_arlen, s_awlen;
    logic        s_wlast;
    int          rd_left, wr_left;
    logic [31:0] rd_addr, wr_addr;
    bit          b_pend;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = pat(i);
        s_id = '0;
        ar_ready = 0; aw_ready = 0; w_ready = 0;
        r_valid = 0; r_last = 0; r_data = '0; r_resp = '0;
        b_valid = 0; b_resp = '0;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; p_wdata = '0;
        rd_left = 0; wr_left = 0; b_pend = 0;
        rd_addr = '0; wr_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ar_ready = 0; aw_ready = 0; w_ready = 0;
                r_valid = 0; r_last = 0; b_valid = 0;
                hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
                p_arv = 0; p_awv = 0; p_wv = 0;
                rd_left = 0; wr_left = 0; b_pend = 0;
                continue;
            end
            if (hs_ar) begin
                ar_addrs.push_back(s_araddr);
                ar_lens.push_back(s_arlen);
                rd_addr = s_araddr;
                rd_left = int'(s_arlen) + 1;
            end
            if (hs_r) begin
                rd_addr = rd_addr + 32'd4;
                rd_left--;
                r_beats++;
            end
            if (hs_aw) begin
                aw_addrs.push_back(s_awaddr);
                aw_lens.push_back(s_awlen);
                wr_addr = s_awaddr;
                wr_left = int'(s_awlen) + 1;
            end
            if (hs_w) begin
                mem[wr_addr[15:2]] = s_wdata;
                checks++;
                if (s_wlast !== (wr_left == 1)) begin
                    errors++;
                    $display("FAIL wlast beats_left=%0d got %b", wr_left, s_wlast);
                end
                wr_addr = wr_addr + 32'd4;
                wr_left--;
                if (wr_left == 0) b_pend = 1;
            end
            if (hs_b) begin
                b_pend = 0;
                b_cnt++;
            end
            if (p_arv && !hs_ar) begin
                checks++;
                if (M_ARValid !== 1'b1) begin
                    errors++;
                    $display("FAIL arvalid_hold got %b want 1", M_ARValid);
                end
            end
            if (p_awv && !hs_aw) begin
                checks++;
                if (M_AWValid !== 1'b1) begin
                    errors++;
                    $display("FAIL awvalid_hold got %b want 1", M_AWValid);
                end
            end
            if (p_wv && !hs_w) begin
                checks++;
                if (M_WValid !== 1'b1 || M_WData !== p_wdata) begin
                    errors++;
                    $display("FAIL wvalid_hold got v=%b d=%h want v=1 d=%h",
                             M_WValid, M_WData, p_wdata);
                end
            end
            ar_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            aw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_left > 0) begin
                if (!r_valid || hs_r)
                    r_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                r_data = mem[rd_addr[15:2]];
                r_last = (rd_left == 1);
                r_resp = '0;
            end else begin
                r_valid = 0;
                r_last  = 0;
            end
            b_valid = b_pend;
            b_resp  = (b_cnt == berr_idx) ? 2'b10 : 2'b00;
            hs_ar = M_ARValid && ar_ready;
            s_araddr = M_ARAddr;
            s_arlen  = M_ARLen;
            hs_r  = M_RReady && r_valid;
            hs_aw = M_AWValid && aw_ready;
            s_awaddr = M_AWAddr;
            s_awlen  = M_AWLen;
            hs_w  = M_WValid && w_ready;
            s_wdata = M_WData;
            s_wlast = M_WLast;
            hs_b  = b_valid && M_BReady;
            p_arv = M_ARValid;
            p_awv = M_AWValid;
            p_wv  = M_WValid;
            p_wdata = M_WData;
        end
    end

    // Stimulus helpers
    task automatic clear_logs;
        ar_addrs.delete(); ar_lens.delete();
        aw_addrs.delete(); aw_lens.delete();
    endtask

    task automatic start_dma(input logic [31:0] s, input logic [31:0] d,
                             input logic [31:0] l);
        @(negedge clk);
        DMASRC = s; DMADST = d; DMALEN = l; DMAEN = 1'b1;
        @(negedge clk);
        DMAEN = 1'b0;
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        DMA_clr = 1'b1;
        @(negedge clk);
        DMA_clr = 1'b0;
    endtask

    task automatic wait_intr(input int maxc, input string tag);
        int n;
        n = 0;
        while (DMA_interrupt !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (DMA_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout interrupt=%b after %0d cycles want 1",
                     tag, DMA_interrupt, n);
        end
    endtask

    // Tests
    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady,
             DMA_interrupt, DMA_error, DMA_busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000",
                     {M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady,
                      DMA_interrupt, DMA_error, DMA_busy});
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({M_ARValid, DMA_busy, DMA_interrupt} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 000",
                     {M_ARValid, DMA_busy, DMA_interrupt});
        end
    endtask

    task automatic test_multi_burst;
        logic [31:0] ea [3];
        logic [31:0] ew [3];
        logic [7:0]  el [3];
        ea = '{32'h1000, 32'h1040, 32'h1080};
        ew = '{32'h2000, 32'h2040, 32'h2080};
        el = '{8'd15, 8'd15, 8'd7};
        clear_logs();
        start_dma(32'h1000, 32'h2000, 32'd40);
        checks++;
        if ({M_ARValid, DMA_busy} !== 2'b11 || M_ARAddr !== 32'h1000 ||
            M_ARSize !== 3'd2 || M_ARBurst !== 2'd1 || M_ARID !== '0) begin
            errors++;
            $display("FAIL first_ar v=%b busy=%b a=%h sz=%0d b=%0d want 1 1 1000 2 1",
                     M_ARValid, DMA_busy, M_ARAddr, M_ARSize, M_ARBurst);
        end
        wait_intr(2000, "multi");
        checks++;
        if (ar_addrs.size() != 3 || aw_addrs.size() != 3) begin
            errors++;
            $display("FAIL multi_count ar=%0d aw=%0d want 3 3",
                     ar_addrs.size(), aw_addrs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ar_addrs[i] !== ea[i] || ar_lens[i] !== el[i] ||
                    aw_addrs[i] !== ew[i] || aw_lens[i] !== el[i]) begin
                    errors++;
                    $display("FAIL multi_burst%0d ar=%h/%0d aw=%h/%0d want %h/%0d %h/%0d",
                             i, ar_addrs[i], ar_lens[i], aw_addrs[i], aw_lens[i],
                             ea[i], el[i], ew[i], el[i]);
                end
            end
        end
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (mem[32'h800 + k] !== pat(32'h400 + k)) begin
                errors++;
                $display("FAIL multi_data word %0d got %h want %h",
                         k, mem[32'h800 + k], pat(32'h400 + k));
            end
        end
        checks++;
        if ({DMA_interrupt, DMA_error, DMA_busy} !== 3'b100) begin
            errors++;
            $display("FAIL multi_status got %b want 100",
                     {DMA_interrupt, DMA_error, DMA_busy});
        end
    endtask

    task automatic test_rearm_ignored;
        clear_logs();
        start_dma(32'h1000, 32'h2000, 32'd4);
        repeat (4) @(negedge clk);
        checks++;
        if (ar_addrs.size() != 0 || DMA_busy !== 1'b0 || DMA_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL rearm_ignored ar=%0d busy=%b intr=%b want 0 0 1",
                     ar_addrs.size(), DMA_busy, DMA_interrupt);
        end
        pulse_clr();
        checks++;
        if ({DMA_interrupt, DMA_error} !== 2'b00) begin
            errors++;
            $display("FAIL clr_intr got %b want 00", {DMA_interrupt, DMA_error});
        end
    endtask

    task automatic test_split_4k;
        clear_logs();
        start_dma(32'h0FF8, 32'h3000, 32'd5);
        wait_intr(1000, "split");
        checks++;
        if (ar_addrs.size() != 2 || aw_addrs.size() != 2) begin
            errors++;
            $display("FAIL split_count ar=%0d aw=%0d want 2 2",
                     ar_addrs.size(), aw_addrs.size());
        end else begin
            checks++;
            if (ar_addrs[0] !== 32'h0FF8 || ar_lens[0] !== 8'd1 ||
                ar_addrs[1] !== 32'h1000 || ar_lens[1] !== 8'd2) begin
                errors++;
                $display("FAIL split_ar got %h/%0d %h/%0d want 0ff8/1 1000/2",
                         ar_addrs[0], ar_lens[0], ar_addrs[1], ar_lens[1]);
            end
            checks++;
            if (aw_addrs[0] !== 32'h3000 || aw_lens[0] !== 8'd1 ||
                aw_addrs[1] !== 32'h3008 || aw_lens[1] !== 8'd2) begin
                errors++;
                $display("FAIL split_aw got %h/%0d %h/%0d want 3000/1 3008/2",
                         aw_addrs[0], aw_lens[0], aw_addrs[1], aw_lens[1]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem[32'hC00 + k] !== pat(32'h3FE + k)) begin
                errors++;
                $display("FAIL split_data word %0d got %h want %h",
                         k, mem[32'hC00 + k], pat(32'h3FE + k));
            end
        end
        pulse_clr();
    endtask

    task automatic test_zero_len;
        clear_logs();
        start_dma(32'h1000, 32'h2000, 32'd0);
        checks++;
        if ({DMA_interrupt, DMA_busy, M_ARValid} !== 3'b000) begin
            errors++;
            $display("FAIL zero_cycle1 intr/busy/arv got %b want 000",
                     {DMA_interrupt, DMA_busy, M_ARValid});
        end
        @(negedge clk);
        checks++;
        if ({DMA_interrupt, DMA_busy} !== 2'b10) begin
            errors++;
            $display("FAIL zero_cycle2 intr/busy got %b want 10",
                     {DMA_interrupt, DMA_busy});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ar_addrs.size() != 0 || aw_addrs.size() != 0 || DMA_error !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_axi ar=%0d aw=%0d err=%b want 0 0 0",
                     ar_addrs.size(), aw_addrs.size(), DMA_error);
        end
        pulse_clr();
    endtask

    task automatic test_clr_vs_done;
        @(negedge clk);
        DMASRC = 32'h0; DMADST = 32'h0; DMALEN = 32'd0; DMAEN = 1'b1;
        @(negedge clk);
        DMAEN = 1'b0;
        DMA_clr = 1'b1;
        @(negedge clk);
        DMA_clr = 1'b0;
        checks++;
        if (DMA_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_done intr got %b want 1", DMA_interrupt);
        end
        pulse_clr();
    endtask

    task automatic test_stalls;
        logic [7:0] el [3];
        el = '{8'd15, 8'd15, 8'd0};
        clear_logs();
        stall = 1'b1;
        start_dma(32'h4004, 32'h6010, 32'd33);
        wait_intr(5000, "stall");
        stall = 1'b0;
        checks++;
        if (ar_lens.size() != 3 || aw_lens.size() != 3) begin
            errors++;
            $display("FAIL stall_count ar=%0d aw=%0d want 3 3",
                     ar_lens.size(), aw_lens.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ar_lens[i] !== el[i] || aw_lens[i] !== el[i]) begin
                    errors++;
                    $display("FAIL stall_len%0d ar=%0d aw=%0d want %0d",
                             i, ar_lens[i], aw_lens[i], el[i]);
                end
            end
        end
        for (int k = 0; k < 33; k++) begin
            checks++;
            if (mem[32'h1804 + k] !== pat(32'h1001 + k)) begin
                errors++;
                $display("FAIL stall_data word %0d got %h want %h",
                         k, mem[32'h1804 + k], pat(32'h1001 + k));
            end
        end
        checks++;
        if (DMA_error !== 1'b0) begin
            errors++;
            $display("FAIL stall_error got %b want 0", DMA_error);
        end
        pulse_clr();
    endtask

    task automatic test_bresp_error;
        clear_logs();
        b_cnt = 0;
        berr_idx = 0;
        start_dma(32'h5000, 32'h5800, 32'd40);
        wait_intr(2000, "berr");
        berr_idx = -1;
        checks++;
        if (ar_addrs.size() != 1 || aw_addrs.size() != 1) begin
            errors++;
            $display("FAIL berr_bursts ar=%0d aw=%0d want 1 1",
                     ar_addrs.size(), aw_addrs.size());
        end
        checks++;
        if ({DMA_interrupt, DMA_error, DMA_busy} !== 3'b110) begin
            errors++;
            $display("FAIL berr_status intr/err/busy got %b want 110",
                     {DMA_interrupt, DMA_error, DMA_busy});
        end
        pulse_clr();
        checks++;
        if ({DMA_interrupt, DMA_error} !== 2'b00) begin
            errors++;
            $display("FAIL berr_clr got %b want 00", {DMA_interrupt, DMA_error});
        end
        clear_logs();
        start_dma(32'hA000, 32'hB000, 32'd8);
        wait_intr(1000, "rearm");
        checks++;
        if ({DMA_interrupt, DMA_error} !== 2'b10 || ar_lens.size() != 1) begin
            errors++;
            $display("FAIL rearm_status intr/err=%b ar=%0d want 10 1",
                     {DMA_interrupt, DMA_error}, ar_lens.size());
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem[32'h2C00 + k] !== pat(32'h2800 + k)) begin
                errors++;
                $display("FAIL rearm_data word %0d got %h want %h",
                         k, mem[32'h2C00 + k], pat(32'h2800 + k));
            end
        end
        pulse_clr();
    endtask

    task automatic test_rst_mid;
        int n;
        clear_logs();
        r_beats = 0;
        start_dma(32'h7000, 32'h7800, 32'd20);
        n = 0;
        while (r_beats < 7 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (r_beats < 7) begin
            errors++;
            $display("FAIL rst_mid_reach beats=%0d want 7", r_beats);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady,
             DMA_busy} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b want 000000",
                     {M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady,
                      DMA_busy});
        end
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        clear_logs();
        start_dma(32'h8000, 32'h9000, 32'd4);
        wait_intr(1000, "post_rst");
        checks++;
        if (ar_lens.size() != 1 || ar_lens[0] !== 8'd3 || DMA_error !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_burst ar=%0d err=%b want 1 burst len 3 err 0",
                     ar_lens.size(), DMA_error);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[32'h2400 + k] !== pat(32'h2000 + k)) begin
                errors++;
                $display("FAIL post_rst_data word %0d got %h want %h",
                         k, mem[32'h2400 + k], pat(32'h2000 + k));
            end
        end
        pulse_clr();
    endtask

    initial begin
        rst = 1'b1;
        DMAEN = 1'b0; DMA_clr = 1'b0;
        DMASRC = '0; DMADST = '0; DMALEN = '0;
        test_reset();
        test_multi_burst();
        test_rearm_ignored();
        test_split_4k();
        test_zero_len();
        test_clr_vs_done();
        test_stalls();
        test_bresp_error();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
